// File: rtl/tile_cfg_pkg.sv
// tile_cfg_pkg: config address field layout, feature IDs, FSM states and address decode.
package tile_cfg_pkg;
  localparam int IDX_LSB = 24;
  localparam int FEAT_LSB = 16;
  localparam int TILE_LSB = 0;
  localparam logic [7:0] FEAT_REG = 8'h00;
  localparam logic [7:0] FEAT_SRAM = 8'h01;
  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef struct packed {
    logic [7:0]  idx;
    logic [7:0]  feature;
    logic [15:0] tile;
  } cfg_addr_t;
  function automatic cfg_addr_t decode_addr(input logic [31:0] addr);
    return '{idx: addr[IDX_LSB+:8], feature: addr[FEAT_LSB+:8], tile: addr[TILE_LSB+:16]};
  endfunction
endpackage

// File: rtl/tile_cfg_responder_if.sv
// tile_cfg_responder_if: broadcast config bus as seen by one tile (request strobes plus registered read return).
interface tile_cfg_responder_if;
  logic [31:0] config_config_addr;
  logic [31:0] config_config_data;
  logic        config_read;
  logic        config_write;
  logic [31:0] read_config_data;
  logic        rd_valid;
  modport master (output config_config_addr, config_config_data, config_read, config_write,
                  input read_config_data, rd_valid);
  modport slave (input config_config_addr, config_config_data, config_read, config_write,
                 output read_config_data, rd_valid);
endinterface

// File: rtl/tile_cfg_responder_sram_bridge.sv
// cfg_sram_bridge: turns accepted feature-1 accesses into registered SRAM strobes and times the read latency.
module cfg_sram_bridge
  import tile_cfg_pkg::*;
#(
  parameter int SRAM_ADDR_W = 8,
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_wdata,
  output logic                   busy,
  output logic                   rd_done
);
  state_t state, state_n;
  logic [1:0] cnt;
  logic go;
  always_comb begin
    busy = state == RD_WAIT;
    go = !busy && (wr_req || rd_req);
    // cnt counts cycles since sram_cen was visible; data is on sram_rdata when it reaches the latency
    rd_done = busy && cnt == 2'(SRAM_LATENCY);
    state_n = busy ? (rd_done ? IDLE : RD_WAIT) : (rd_req && !wr_req ? RD_WAIT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sram_cen <= 1'b0;
      sram_wen <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= busy ? cnt + 2'd1 : 2'd0;
      sram_cen <= go;
      sram_wen <= go && wr_req;
      if (go) begin
        sram_addr <= addr;
        sram_wdata <= wdata;
      end
    end
  end
endmodule

// File: rtl/tile_cfg_responder.sv
// tile_cfg_responder: per-tile config target with feature-0 register file, feature-1 SRAM bridge and OR-able read return.
// Build option CFG_ACCESS_ERR_EN adds a sticky cfg_err flag for illegal selected accesses.
module tile_cfg_responder
  import tile_cfg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SRAM_ADDR_W = 8,
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [15:0]              tile_id,
  tile_cfg_responder_if.slave      bus,
  output logic [NUM_REGS*32-1:0]   cfg_regs,
  output logic                     flush,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [SRAM_ADDR_W-1:0]   sram_addr,
  output logic [SRAM_DATA_W-1:0]   sram_wdata,
  input  logic [SRAM_DATA_W-1:0]   sram_rdata
`ifdef CFG_ACCESS_ERR_EN
  ,
  output logic                     cfg_err
`endif
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  cfg_addr_t a;
  logic sel, busy, rd_done, wr, rd, is_reg, is_sram, in_range;
  logic [IW-1:0] ri;
  logic [31:0] regs [NUM_REGS];
  always_comb begin
    a = decode_addr(bus.config_config_addr);
    sel = a.tile == tile_id;
    wr = sel && !busy && bus.config_write;
    rd = sel && !busy && bus.config_read && !bus.config_write;
    is_reg = a.feature == FEAT_REG;
    is_sram = a.feature == FEAT_SRAM;
    in_range = 32'(a.idx) < NUM_REGS;
    ri = a.idx[IW-1:0];
  end
  cfg_sram_bridge #(
    .SRAM_ADDR_W(SRAM_ADDR_W),
    .SRAM_DATA_W(SRAM_DATA_W),
    .SRAM_LATENCY(SRAM_LATENCY)
  ) u_bridge (
    .clk(clk),
    .reset(reset),
    .wr_req(wr && is_sram && stall),
    .rd_req(rd && is_sram && stall),
    .addr(a.idx[SRAM_ADDR_W-1:0]),
    .wdata(bus.config_config_data[SRAM_DATA_W-1:0]),
    .sram_cen(sram_cen),
    .sram_wen(sram_wen),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .busy(busy),
    .rd_done(rd_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      bus.read_config_data <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (wr && is_reg && in_range) regs[ri] <= bus.config_config_data;
      bus.rd_valid <= 1'b0;
      if (rd_done) begin
        bus.read_config_data <= 32'(sram_rdata);
        bus.rd_valid <= 1'b1;
      end else if (bus.config_read && !sel) begin
        bus.read_config_data <= '0;
      end else if (rd && !is_sram) begin
        bus.read_config_data <= (is_reg && in_range) ? regs[ri] : '0;
        bus.rd_valid <= 1'b1;
      end else if (rd && !stall) begin
        bus.read_config_data <= '0;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign cfg_regs[32*i+:32] = regs[i];
  end
  assign flush = |regs[0][15:8];
`ifdef CFG_ACCESS_ERR_EN
  logic err_hit;
  assign err_hit = sel && (bus.config_read || bus.config_write) &&
                   (busy || (is_sram && !stall) || (is_reg && !in_range) || (!is_reg && !is_sram));
  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else if (wr && is_reg && a.idx == 8'd0 && bus.config_config_data[31]) cfg_err <= 1'b0;
    else if (err_hit) cfg_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_tile_cfg_responder.sv
// tb_tile_cfg_responder: directed vectors against hand-computed values, with a 1-cycle-latency SRAM model.
module tb_tile_cfg_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic [15:0] tile_id = 16'h0302;
  logic [255:0] cfg_regs;
  logic flush, sram_cen, sram_wen;
  logic [7:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = '0;
  logic [15:0] mem [256];
  int wr_cnt = 0;
  int w0;
  int n_cmp = 0;
  int n_err = 0;
`ifdef CFG_ACCESS_ERR_EN
  logic cfg_err;
`endif
  tile_cfg_responder_if bus ();
  tile_cfg_responder dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .tile_id(tile_id),
    .bus(bus.slave),
    .cfg_regs(cfg_regs),
    .flush(flush),
    .sram_cen(sram_cen),
    .sram_wen(sram_wen),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
`ifdef CFG_ACCESS_ERR_EN
    ,
    .cfg_err(cfg_err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (sram_cen) begin
      if (sram_wen) begin
        mem[sram_addr] <= sram_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.config_config_addr = a;
    bus.config_config_data = d;
    bus.config_write = 1'b1;
    tick();
    bus.config_write = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    bus.config_config_addr = a;
    bus.config_read = 1'b1;
    tick();
    bus.config_read = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[5] = 16'h01CB;
    bus.config_config_addr = '0;
    bus.config_config_data = '0;
    bus.config_read = 1'b0;
    bus.config_write = 1'b0;
    tick();
    tick();
    chk("rst_rdata", bus.read_config_data, 0);
    chk("rst_rdv", 32'(bus.rd_valid), 0);
    chk("rst_cen", 32'(sram_cen), 0);
    chk("rst_wen", 32'(sram_wen), 0);
    chk("rst_saddr", 32'(sram_addr), 0);
    chk("rst_swdata", 32'(sram_wdata), 0);
    chk("rst_regs", 32'(|cfg_regs), 0);
    chk("rst_flush", 32'(flush), 0);
    reset = 1'b0;
    wr(32'h0000_0201, 32'h1234);
    chk("nosel_wr_regs", 32'(|cfg_regs), 0);
    rd(32'h0000_0201);
    chk("nosel_rd_rdv", 32'(bus.rd_valid), 0);
    chk("nosel_rd_data", bus.read_config_data, 0);
    rd(32'h0000_0302);
    chk("reg0_zero_rdv", 32'(bus.rd_valid), 1);
    chk("reg0_zero_data", bus.read_config_data, 0);
    wr(32'h0000_0302, 32'h001C_7E00);
    chk("flush_set", 32'(flush), 1);
    rd(32'h0000_0302);
    chk("reg0_rdv", 32'(bus.rd_valid), 1);
    chk("reg0_data", bus.read_config_data, 32'h001C_7E00);
    tick();
    chk("rdv_pulse", 32'(bus.rd_valid), 0);
    chk("rdata_hold", bus.read_config_data, 32'h001C_7E00);
    wr(32'h0000_0302, 32'h001C_0000);
    chk("flush_clr", 32'(flush), 0);
    rd(32'h0000_0201);
    chk("nosel_clear", bus.read_config_data, 0);
    wr(32'h0700_0302, 32'hDEAD_BEEF);
    chk("reg7_flat", cfg_regs[255:224], 32'hDEAD_BEEF);
    rd(32'h0800_0302);
    chk("oor_rdv", 32'(bus.rd_valid), 1);
    chk("oor_data", bus.read_config_data, 0);
    rd(32'h0700_0302);
    chk("reg7_data", bus.read_config_data, 32'hDEAD_BEEF);
    rd(32'h0002_0302);
    chk("unk_feat_rdv", 32'(bus.rd_valid), 1);
    chk("unk_feat_data", bus.read_config_data, 0);
    bus.config_config_addr = 32'h0100_0302;
    bus.config_config_data = 32'h55;
    bus.config_read = 1'b1;
    bus.config_write = 1'b1;
    tick();
    bus.config_read = 1'b0;
    bus.config_write = 1'b0;
    chk("rw_rdv", 32'(bus.rd_valid), 0);
    chk("rw_reg1", cfg_regs[63:32], 32'h55);
    tile_id = 16'h0201;
    stall = 1'b1;
    rd(32'h0501_0201);
    chk("srd_cen", 32'(sram_cen), 1);
    chk("srd_wen", 32'(sram_wen), 0);
    chk("srd_addr", 32'(sram_addr), 5);
    chk("srd_rdv1", 32'(bus.rd_valid), 0);
    tick();
    chk("srd_cen_pulse", 32'(sram_cen), 0);
    chk("srd_rdv2", 32'(bus.rd_valid), 0);
    tick();
    chk("srd_rdv3", 32'(bus.rd_valid), 1);
    chk("srd_data", bus.read_config_data, 32'h0000_01CB);
    tick();
    chk("srd_rdv_pulse", 32'(bus.rd_valid), 0);
    w0 = wr_cnt;
    wr(32'h0501_0201, 32'h0099);
    chk("swr_cen", 32'(sram_cen), 1);
    chk("swr_wen", 32'(sram_wen), 1);
    chk("swr_addr", 32'(sram_addr), 5);
    chk("swr_wdata", 32'(sram_wdata), 32'h0099);
    tick();
    chk("swr_cen_pulse", 32'(sram_cen), 0);
    chk("swr_count", 32'(wr_cnt - w0), 1);
    w0 = wr_cnt;
    bus.config_config_addr = 32'h0601_0201;
    bus.config_config_data = 32'h0007;
    bus.config_write = 1'b1;
    tick();
    tick();
    bus.config_write = 1'b0;
    tick();
    tick();
    chk("swr_held_count", 32'(wr_cnt - w0), 2);
    rd(32'h0501_0201);
    tick();
    tick();
    chk("srd_back_data", bus.read_config_data, 32'h0000_0099);
    stall = 1'b0;
    wr(32'h0501_0201, 32'h0001);
    chk("nostall_wr_cen", 32'(sram_cen), 0);
`ifdef CFG_ACCESS_ERR_EN
    chk("nostall_err", 32'(cfg_err), 1);
    wr(32'h0000_0201, 32'h8000_0000);
    chk("err_clear", 32'(cfg_err), 0);
`endif
    rd(32'h0501_0201);
    chk("nostall_rd_cen", 32'(sram_cen), 0);
    chk("nostall_rd_rdv", 32'(bus.rd_valid), 0);
    chk("nostall_rd_data", bus.read_config_data, 0);
    tick();
    chk("nostall_rdv_late", 32'(bus.rd_valid), 0);
    chk("nostall_cen_late", 32'(sram_cen), 0);
    stall = 1'b1;
    wr(32'h0000_0201, 32'h0000_0A00);
    rd(32'h0000_0201);
    chk("pre_rst_data", bus.read_config_data, 32'h0000_0A00);
    rd(32'h0501_0201);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_rdv", 32'(bus.rd_valid), 0);
    chk("midrst_data", bus.read_config_data, 0);
    chk("midrst_regs", 32'(|cfg_regs), 0);
    tick();
    chk("midrst_rdv2", 32'(bus.rd_valid), 0);
    tick();
    chk("midrst_rdv3", 32'(bus.rd_valid), 0);
    rd(32'h0000_0201);
    chk("midrst_idle_rdv", 32'(bus.rd_valid), 1);
    chk("midrst_idle_data", bus.read_config_data, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tile_cfg_responder.md
Name: tile_cfg_responder

Overview:
- Config-bus target inside each CGRA tile. It answers the broadcast config_config_addr/config_config_data/config_read/config_write bus driven by the global controller or test initiator.
- Decodes the tile ID and feature ID fields. Holds the tile's feature-0 configuration registers and produces the flush control from them.
- Bridges feature-1 accesses onto the tile SRAM port for prefill and readback.
- Returns read data on read_config_data. A non-selected tile drives zero, so the interconnect can OR-reduce the read data from all tiles.

Parameters:
- NUM_REGS, 8, number of 32-bit feature-0 config registers (2..256).
- SRAM_ADDR_W, 8, SRAM word address width (≤ 8).
- SRAM_DATA_W, 16, SRAM word width (≤ 32).
- SRAM_LATENCY, 1, cycles from sram_cen to valid sram_rdata (1..3).

Ports:
- clk  in  1  clock; everything synchronous to the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  tile stall; SRAM config access is legal only while this is 1.
- tile_id  in  16  strapped {x[7:0], y[7:0]} of this tile.
- config_config_addr  in  32  {idx[7:0], feature[7:0], tile[15:0]}.
- config_config_data  in  32  write data.
- config_read  in  1  read strobe.
- config_write  in  1  write strobe.
- read_config_data  out  32  registered read data; 0 when not selected.
- rd_valid  out  1  one-cycle pulse when read_config_data is loaded.
- cfg_regs  out  NUM_REGS*32  flattened feature-0 registers; reg i occupies [32i+31:32i].
- flush  out  1  equals |cfg_regs[15:8] (reg 0, bits 15:8).
- sram_cen  out  1  SRAM access strobe, one cycle per access.
- sram_wen  out  1  1 = write, 0 = read; qualified by sram_cen.
- sram_addr  out  SRAM_ADDR_W  equals idx[SRAM_ADDR_W-1:0].
- sram_wdata  out  SRAM_DATA_W  equals config_config_data[SRAM_DATA_W-1:0].
- sram_rdata  in  SRAM_DATA_W  SRAM read data.

Behaviour:
- Reset values: all regs 0, read_config_data 0, rd_valid 0, sram_cen 0, sram_wen 0, sram_addr 0, sram_wdata 0, state IDLE.
- Selection: sel = (addr[15:0] == tile_id). Non-selected cycles have no side effects.
- Both read and write high in the same cycle: the write wins, the read is dropped, rd_valid stays 0.
- FSM states: IDLE, RD_WAIT.
- IDLE, feature 0, write, idx < NUM_REGS: the register updates at that edge; cfg_regs and flush change the next cycle.
- IDLE, feature 0, read: read_config_data ← reg[idx] at that edge, with rd_valid = 1, so the data is visible one cycle after config_read. An idx ≥ NUM_REGS returns 0 with rd_valid = 1.
- IDLE, feature 1, write, stall = 1: sram_cen = 1 and sram_wen = 1 for exactly one cycle, registered, starting the cycle after the strobe. A write held high N cycles issues N SRAM writes.
- IDLE, feature 1, read, stall = 1:
  - Registered sram_cen = 1, sram_wen = 0 for one cycle; go to RD_WAIT.
  - A counter waits SRAM_LATENCY cycles after sram_cen.
  - read_config_data ← zero-extended sram_rdata, rd_valid = 1, return to IDLE.
  - Total latency from config_read to data is SRAM_LATENCY + 2 cycles, which must be ≤ 5.
- Feature 1 with stall = 0: the access is ignored. No SRAM strobe; reads leave read_config_data at 0 with rd_valid = 0.
- Other feature IDs: writes are ignored; reads return 0 with rd_valid = 1.
- In RD_WAIT, all bus strobes are ignored.
- read_config_data holds its last value until the next accepted read, or clears to 0 the cycle after any non-selected read.
- A config write to reg 0 can raise and lower flush directly; reg 0 is not gated by stall.
- Reset mid-RD_WAIT: immediate return to IDLE; the pending data is discarded.

Optional Feature:
- Macro: CFG_ACCESS_ERR_EN.
- Defined: adds output cfg_err (1 bit), sticky, cleared by reset or by writing reg 0 bit 31.
- cfg_err is set on any selected:
  - feature-1 access with stall = 0;
  - idx ≥ NUM_REGS;
  - unknown feature ID;
  - strobe while in RD_WAIT.
- Undefined: no port, and those accesses are silently ignored as above.

Decomposition:
- Package tile_cfg_pkg:
  - field-position localparams: IDX_LSB = 24, FEAT_LSB = 16, TILE_LSB = 0;
  - FEAT_REG = 8'h00, FEAT_SRAM = 8'h01;
  - state enum {IDLE, RD_WAIT};
  - function decode_addr returning a struct {idx, feature, tile}.
- One sub-module: cfg_sram_bridge, containing the RD_WAIT FSM, latency counter and SRAM strobes. The top level keeps the register file, decode and read mux.

Test Plan:
- Reset, then write addr 0x0000_0302 data 0x001C_7E00 with tile_id 0x0302:
  - flush = 1 the next cycle;
  - reading the same addr returns 0x001C_7E00 one cycle later with rd_valid;
  - writing 0x001C_0000 makes flush = 0.
- Write 0x0000_0201 data 0x1234 with tile_id 0x0302: no register change; the read returns 0, and so does a read of 0x0000_0302.
- stall = 1, write addr 0x0501_0201 data 0x0099 (tile 0x0201): one sram_cen/sram_wen pulse with sram_addr 0x05, sram_wdata 0x0099.
- stall = 1, read 0x0501_0201 with a model returning 0x01CB at SRAM_LATENCY = 1: read_config_data = 0x0000_01CB and rd_valid 3 cycles after config_read.
- stall = 0, SRAM read or write: no sram_cen and no rd_valid; with CFG_ACCESS_ERR_EN, cfg_err = 1 the next cycle.
- Assert reset during RD_WAIT: state is IDLE, rd_valid never pulses, and read_config_data = 0 after reset.
